// File: rtl/fsrcnn_pkg.sv
// Shared types and constants for the psum post-processing stage.
// Holds the FSM state encoding, datapath widths and saturation helpers.
package fsrcnn_pkg;

    localparam int LANES      = 4;
    localparam int PSUM_W     = 32;
    localparam int DATA_W     = 16;
    localparam int FRAC_SHIFT = 8;
    localparam int ALPHA_FRAC = 14;
    localparam int ADDR_W     = 16;
    localparam int CNT_W      = 16;
    localparam int PROD_W     = PSUM_W + DATA_W;

    localparam logic [PSUM_W-1:0] PSUM_MAX = 32'h7FFF_FFFF;
    localparam logic [PSUM_W-1:0] PSUM_MIN = 32'h8000_0000;
    localparam logic [DATA_W-1:0] DATA_MAX = 16'h7FFF;
    localparam logic [DATA_W-1:0] DATA_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // In range when every bit above the target sign bit matches the sign.
    function automatic logic [PSUM_W-1:0] sat_psum(input logic [PROD_W-1:0] v);
        logic [PSUM_W-1:0] r;
        if ((&v[PROD_W-1:PSUM_W-1]) || (~|v[PROD_W-1:PSUM_W-1])) begin
            r = v[PSUM_W-1:0];
        end else if (v[PROD_W-1]) begin
            r = PSUM_MIN;
        end else begin
            r = PSUM_MAX;
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] sat_data(input logic [PSUM_W:0] v);
        logic [DATA_W-1:0] r;
        if ((&v[PSUM_W:DATA_W-1]) || (~|v[PSUM_W:DATA_W-1])) begin
            r = v[DATA_W-1:0];
        end else if (v[PSUM_W]) begin
            r = DATA_MIN;
        end else begin
            r = DATA_MAX;
        end
        return r;
    endfunction

endpackage

// File: rtl/pp_lane.sv
// One output channel of the post-processor: bias add, activation, requantise.
// Activation is per-lane PReLU when PRELU_EN is defined, plain ReLU otherwise.
module pp_lane
    import fsrcnn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [PSUM_W-1:0] psum,
    input  logic [PSUM_W-1:0] bias,
    input  logic [DATA_W-1:0] alpha,
    input  logic              out_en,
    output logic [DATA_W-1:0] y
);

    localparam logic [PSUM_W:0] RND = 33'd1 << (FRAC_SHIFT - 1);

    logic [PSUM_W:0]   sum_s;
    logic [PSUM_W-1:0] s1_r;
    logic [PSUM_W-1:0] act_s;
    logic [PSUM_W-1:0] a2_r;
    logic [PSUM_W:0]   rnd_s;
    logic [PSUM_W:0]   shr_s;
    logic [DATA_W-1:0] y_nxt_s;
    logic [DATA_W-1:0] y_r;

    // S1 combinational: 33-bit bias add
    always_comb begin
        sum_s = {psum[PSUM_W-1], psum} + {bias[PSUM_W-1], bias};
    end

`ifdef PRELU_EN
    logic [PROD_W-1:0] prod_s;
    logic [PROD_W-1:0] scaled_s;

    // S2 combinational: negative values scaled by the Q2.14 slope
    always_comb begin
        prod_s   = $signed({{DATA_W{s1_r[PSUM_W-1]}}, s1_r})
                 * $signed({{PSUM_W{alpha[DATA_W-1]}}, alpha});
        scaled_s = $signed(prod_s) >>> ALPHA_FRAC;
        if (s1_r[PSUM_W-1]) begin
            act_s = sat_psum(scaled_s);
        end else begin
            act_s = s1_r;
        end
    end
`else
    logic unused_alpha_s;
    assign unused_alpha_s = ^alpha;

    // S2 combinational: ReLU clamps negatives to zero
    always_comb begin
        if (s1_r[PSUM_W-1]) begin
            act_s = {PSUM_W{1'b0}};
        end else begin
            act_s = s1_r;
        end
    end
`endif

    // S3 combinational: round-half-up then arithmetic shift into output format
    always_comb begin
        rnd_s   = {a2_r[PSUM_W-1], a2_r} + RND;
        shr_s   = $signed(rnd_s) >>> FRAC_SHIFT;
        y_nxt_s = sat_data(shr_s);
    end

    // Pipeline registers; the output register only loads on a valid beat
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= {PSUM_W{1'b0}};
            a2_r <= {PSUM_W{1'b0}};
            y_r  <= {DATA_W{1'b0}};
        end else begin
            s1_r <= sat_psum({{(PROD_W-PSUM_W-1){sum_s[PSUM_W]}}, sum_s});
            a2_r <= act_s;
            if (out_en) begin
                y_r <= y_nxt_s;
            end
        end
    end

    assign y = y_r;

endmodule

// File: rtl/psum_postproc.sv
// Psum post-processor top: pass FSM, beat counting, address generation and
// the valid chain around LANES pp_lane datapaths. PRELU_EN selects PReLU vs ReLU.
module psum_postproc
    import fsrcnn_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        pix_num,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [LANES*PSUM_W-1:0] bias,
    input  logic [LANES*DATA_W-1:0] alpha,
    input  logic                    psum_valid,
    output logic                    psum_ready,
    input  logic [LANES*PSUM_W-1:0] psum_i,
    output logic                    out_we,
    output logic [ADDR_W-1:0]       out_addr,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic                    busy,
    output logic                    done
);

    state_t                  state_r;
    state_t                  next_state_s;
    logic                    start_ok_s;
    logic                    accept_s;
    logic                    ready_nxt_s;
    logic [CNT_W-1:0]        acc_cnt_r;
    logic [CNT_W-1:0]        acc_cnt_nxt_s;
    logic [CNT_W-1:0]        pix_num_r;
    logic [CNT_W-1:0]        pix_num_nxt_s;
    logic [CNT_W-1:0]        out_idx_r;
    logic [ADDR_W-1:0]       base_addr_r;
    logic [ADDR_W-1:0]       out_addr_r;
    logic [LANES*PSUM_W-1:0] bias_r;
    logic [LANES*DATA_W-1:0] alpha_r;
    logic                    v1_r;
    logic                    v2_r;
    logic                    out_we_r;
    logic                    ready_r;
    logic                    busy_r;
    logic                    done_r;

    // Next-state decode for the pass FSM
    always_comb begin
        next_state_s = state_r;
        start_ok_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    start_ok_s = 1'b1;
                    if (pix_num == {CNT_W{1'b0}}) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = RUN;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (acc_cnt_r == pix_num_r) begin
                    next_state_s = DRAIN;
                end else begin
                    next_state_s = RUN;
                end
            end
            DRAIN: begin
                if (!v1_r && !v2_r) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = DRAIN;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Next accept count; ready is precomputed so it can leave a flop
    always_comb begin
        accept_s = psum_valid && ready_r;
        if (start_ok_s) begin
            acc_cnt_nxt_s = {CNT_W{1'b0}};
            pix_num_nxt_s = pix_num;
        end else if (accept_s) begin
            acc_cnt_nxt_s = acc_cnt_r + 16'd1;
            pix_num_nxt_s = pix_num_r;
        end else begin
            acc_cnt_nxt_s = acc_cnt_r;
            pix_num_nxt_s = pix_num_r;
        end
        ready_nxt_s = (next_state_s == RUN) && (acc_cnt_nxt_s < pix_num_nxt_s);
    end

    // State, configuration, counters, valid chain and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            acc_cnt_r   <= {CNT_W{1'b0}};
            pix_num_r   <= {CNT_W{1'b0}};
            out_idx_r   <= {CNT_W{1'b0}};
            base_addr_r <= {ADDR_W{1'b0}};
            bias_r      <= {(LANES*PSUM_W){1'b0}};
            alpha_r     <= {(LANES*DATA_W){1'b0}};
            out_addr_r  <= {ADDR_W{1'b0}};
            v1_r        <= 1'b0;
            v2_r        <= 1'b0;
            out_we_r    <= 1'b0;
            ready_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            acc_cnt_r <= acc_cnt_nxt_s;
            ready_r   <= ready_nxt_s;
            busy_r    <= (next_state_s != IDLE);
            done_r    <= (next_state_s == DONE);
            v1_r      <= accept_s;
            v2_r      <= v1_r;
            out_we_r  <= v2_r;
            if (start_ok_s) begin
                pix_num_r   <= pix_num;
                base_addr_r <= base_addr;
                bias_r      <= bias;
                alpha_r     <= alpha;
                out_idx_r   <= {CNT_W{1'b0}};
            end else if (v2_r) begin
                out_addr_r <= base_addr_r + out_idx_r;
                out_idx_r  <= out_idx_r + 16'd1;
            end
        end
    end

    // Lane 0 sits in the most significant slice of every packed bus
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        pp_lane u_lane (
            .clk    (clk),
            .rst    (rst),
            .psum   (psum_i[(LANES-1-g)*PSUM_W +: PSUM_W]),
            .bias   (bias_r[(LANES-1-g)*PSUM_W +: PSUM_W]),
            .alpha  (alpha_r[(LANES-1-g)*DATA_W +: DATA_W]),
            .out_en (v2_r),
            .y      (out_data[(LANES-1-g)*DATA_W +: DATA_W])
        );
    end

    assign psum_ready = ready_r;
    assign out_we     = out_we_r;
    assign out_addr   = out_addr_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_psum_postproc.sv
// Scoreboard bench for psum_postproc; expected words come from a longint
// reference model (PReLU when PRELU_EN is defined, ReLU otherwise).
module tb_psum_postproc;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [15:0]  pix_num = 16'd0;
    logic [15:0]  base_addr = 16'd0;
    logic [127:0] bias = 128'd0;
    logic [63:0]  alpha = 64'd0;
    logic         psum_valid = 1'b0;
    logic         psum_ready;
    logic [127:0] psum_i = 128'd0;
    logic         out_we;
    logic [15:0]  out_addr;
    logic [63:0]  out_data;
    logic         busy;
    logic         done;

    typedef struct {
        logic [15:0] addr;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t         sb_q[$];
    logic [127:0] beat_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           last_we_cyc = -1;
    logic         start_expected = 1'b0;
    logic [15:0]  cur_base = 16'd0;
    logic [15:0]  push_idx = 16'd0;
    logic [127:0] cur_bias = 128'd0;
    logic [63:0]  cur_alpha = 64'd0;
    exp_t         push_e;
    exp_t         mon_e;

    always #5 clk = ~clk;

    psum_postproc dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pix_num    (pix_num),
        .base_addr  (base_addr),
        .bias       (bias),
        .alpha      (alpha),
        .psum_valid (psum_valid),
        .psum_ready (psum_ready),
        .psum_i     (psum_i),
        .out_we     (out_we),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_word(input logic [127:0] p, input logic [127:0] b,
                                               input logic [63:0] a);
        logic [63:0] r;
        longint s, act, y, al;
        r = 64'd0;
        for (int i = 0; i < 4; i++) begin
            s  = longint'($signed(p[127-32*i -: 32])) + longint'($signed(b[127-32*i -: 32]));
            al = longint'($signed(a[63-16*i -: 16]));
            if (s > 64'sd2147483647) s = 64'sd2147483647;
            if (s < -64'sd2147483648) s = -64'sd2147483648;
            if (s >= 0) begin
                act = s;
            end else begin
`ifdef PRELU_EN
                act = (s * al) >>> 14;
                if (act > 64'sd2147483647) act = 64'sd2147483647;
                if (act < -64'sd2147483648) act = -64'sd2147483648;
`else
                act = 0;
`endif
            end
            y = (act + 64'sd128) >>> 8;
            if (y > 64'sd32767) y = 64'sd32767;
            if (y < -64'sd32768) y = -64'sd32768;
            r[63-16*i -: 16] = y[15:0];
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard push on every accepted beat, config captured on an expected start
    always @(posedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else if (start && start_expected) begin
            cur_base  = base_addr;
            cur_bias  = bias;
            cur_alpha = alpha;
            push_idx  = 16'd0;
        end else if (psum_valid && psum_ready) begin
            push_e.addr = cur_base + push_idx;
            push_e.data = model_word(psum_i, cur_bias, cur_alpha);
            push_e.cyc  = cyc + 3;
            sb_q.push_back(push_e);
            push_idx = push_idx + 16'd1;
        end
    end

    // Output monitor: every write must match the oldest expected entry
    always @(negedge clk) begin
        if (out_we) begin
            if (sb_q.size() == 0) begin
                check_val("unexp_we", 128'd1, 128'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("wr_addr", out_addr, mon_e.addr);
                check_val("wr_data", out_data, mon_e.data);
                check_val("wr_lat", cyc, mon_e.cyc);
            end
            last_we_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n, input logic [15:0] base,
                            input logic [127:0] b, input logic [63:0] al);
        start = 1'b1;
        start_expected = 1'b1;
        pix_num = n;
        base_addr = base;
        bias = b;
        alpha = al;
        tick();
        start = 1'b0;
        start_expected = 1'b0;
    endtask

    task automatic drive_beats(input bit toggle, input int limit);
        int guard = 0;
        int acc_n = 0;
        logic acc;
        while (beat_q.size() > 0 && acc_n < limit && guard < 300) begin
            psum_valid = toggle ? ((guard % 2) == 0) : 1'b1;
            psum_i = beat_q[0];
            @(negedge clk);
            acc = psum_valid && psum_ready;
            tick();
            if (acc) begin
                void'(beat_q.pop_front());
                acc_n++;
            end
            guard++;
        end
        psum_valid = 1'b0;
        check_val("drive_bound", guard < 300, 1);
    endtask

    task automatic wait_done(input string tag);
        logic seen = 1'b0;
        int dc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                dc = cyc;
                break;
            end
        end
        check_val({tag, "_done_seen"}, seen, 1);
        check_val({tag, "_done_lat"}, dc, last_we_cyc + 1);
        @(negedge clk);
        check_val({tag, "_done_pulse"}, done, 0);
        check_val({tag, "_busy_idle"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic ready_seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_ready", psum_ready, 0);
        check_val("rst_we", out_we, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_addr", out_addr, 0);
        check_val("rst_data", out_data, 0);
        rst = 1'b0;
        tick();

        // Basic: four identical beats of 0x300 per lane
        for (int i = 0; i < 4; i++) beat_q.push_back({4{32'h0000_0300}});
        do_start(16'd4, 16'h0100, 128'd0, {4{16'h1000}});
        check_val("t1_busy", busy, 1);
        drive_beats(1'b0, 100);
        wait_done("t1");
        check_val("t1_last_data", out_data, 64'h0003_0003_0003_0003);

        // Negative inputs: PReLU slope 0.25 or ReLU clamp, lanes differ
        beat_q.push_back({4{32'hFFFF_FC00}});
        beat_q.push_back({32'h0000_0300, 32'hFFFF_FC00, 32'h0000_1000, 32'hFFFF_8000});
        do_start(16'd2, 16'h0200, 128'd0, {16'h1000, 16'h1000, 16'h1000, 16'h2000});
        drive_beats(1'b0, 100);
        wait_done("t2");

        // Saturation at the bias add, both polarities
        beat_q.push_back({32'h7FFF_FF00, 32'h8000_0100, 32'h7FFF_FF00, 32'h8000_0100});
        beat_q.push_back({4{32'h0000_0000}});
        do_start(16'd2, 16'h0300, {32'h0000_1000, 32'hFFFF_F000, 32'h0000_1000, 32'hFFFF_F000},
                 {4{16'h1000}});
        drive_beats(1'b0, 100);
        wait_done("t3");

        // Random full-range beats with gaps in valid
        for (int i = 0; i < 6; i++) beat_q.push_back({$urandom, $urandom, $urandom, $urandom});
        do_start(16'd6, 16'h1234, {$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom});
        drive_beats(1'b1, 100);
        wait_done("trnd");

        // Empty pass: done one cycle after start, no ready, no writes
        psum_valid = 1'b1;
        do_start(16'd0, 16'h0500, 128'd0, 64'd0);
        @(negedge clk);
        check_val("t4_done", done, 1);
        ready_seen = psum_ready;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ready_seen = ready_seen | psum_ready;
            check_val("t4_done_once", done, 0);
        end
        check_val("t4_ready", ready_seen, 0);
        psum_valid = 1'b0;

        // Address wrap with toggling valid
        for (int i = 0; i < 3; i++) beat_q.push_back({4{32'h0000_0100 * (i + 1)}});
        do_start(16'd3, 16'hFFFE, {4{32'h0000_0080}}, {4{16'h1000}});
        drive_beats(1'b1, 100);
        wait_done("t5");
        check_val("t5_wrap_addr", out_addr, 16'h0000);

        // Reset mid-pass after two accepts abandons the pass
        for (int i = 0; i < 8; i++) beat_q.push_back({4{32'h0000_0400}});
        do_start(16'd8, 16'h0400, 128'd0, 64'd0);
        drive_beats(1'b0, 2);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        beat_q.delete();
        @(negedge clk);
        check_val("t6_busy", busy, 0);
        check_val("t6_ready", psum_ready, 0);
        repeat (6) @(negedge clk);
        check_val("t6_sb_clear", sb_q.size(), 0);

        // Clean pass afterwards; a start while busy must be ignored
        beat_q.push_back({32'h0000_0500, 32'h0000_0600, 32'h0000_0700, 32'h0000_0800});
        beat_q.push_back({32'hFFFF_F000, 32'h0000_0000, 32'h0001_0000, 32'h0000_0080});
        do_start(16'd2, 16'h0600, 128'd0, {4{16'h4000}});
        start = 1'b1;
        pix_num = 16'd5;
        base_addr = 16'h4000;
        bias = {4{32'h0001_0000}};
        tick();
        start = 1'b0;
        drive_beats(1'b0, 100);
        wait_done("t6b");
        repeat (4) @(negedge clk);
        check_val("sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
